// File: rtl/icache_assoc_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_assoc_if
//  Purpose  : Bundles the fetch-side, memory-side and statistics signals of
//             icache_assoc so the cache and its environment share one port.
//  Ports    : fetch side  imemREN, imemaddr, flush -> ihit, imemload, busy
//             memory side iwait, iload -> iREN, iaddr
//             statistics  hit_count, miss_count
//  Modports : slave  - the cache itself
//             master - the datapath / arbiter / test environment
//  Revision : 1.0  initial release
// ============================================================================
interface icache_assoc_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        flush;
   logic        ihit;
   logic [31:0] imemload;
   logic        busy;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   modport slave (
      input  imemREN, imemaddr, flush, iwait, iload,
      output ihit, imemload, busy, iREN, iaddr, hit_count, miss_count
   );

   modport master (
      output imemREN, imemaddr, flush, iwait, iload,
      input  ihit, imemload, busy, iREN, iaddr, hit_count, miss_count
   );
endinterface
`default_nettype wire

// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
//  Module   : icache_assoc
//  Purpose  : Read-only set-associative instruction cache. Hits return in the
//             request cycle; misses fill a whole block from memory into the
//             lowest invalid way (or the round-robin victim), then the
//             re-presented request hits. Flush invalidates one set per cycle.
//  Ports    : CLK  - clock, rising edge
//             RST  - asynchronous active-high reset
//             bus  - icache_assoc_if.slave (fetch, memory and counter signals)
//  Revision : 1.0  initial release
// ============================================================================
module icache_assoc #(
   parameter int SETS        = 8,
   parameter int WAYS        = 2,
   parameter int BLOCK_WORDS = 2
) (
   input  logic          CLK,
   input  logic          RST,
   icache_assoc_if.slave bus
);
   localparam int C_WB   = $clog2(BLOCK_WORDS);
   localparam int C_SB   = $clog2(SETS);
   localparam int C_WCW  = (C_WB > 0) ? C_WB : 1;
   localparam int C_WYW  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int C_TAGW = 30 - C_WB - C_SB;
   localparam logic [31:0] C_BLK_MASK = ~((32'(BLOCK_WORDS) << 2) - 32'd1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   // Storage
   logic [WAYS-1:0]   r_valid [SETS];
   logic [C_TAGW-1:0] r_tag   [SETS][WAYS];
   logic [31:0]       r_data  [SETS][WAYS][BLOCK_WORDS];
   logic [C_WYW-1:0]  r_vptr  [SETS];

   // Control
   logic [1:0]        r_state, w_next;
   logic [31:0]       r_fill_addr;
   logic [C_WYW-1:0]  r_fill_way;
   logic              r_fill_evict;   // victim held a valid block
   logic [C_WCW-1:0]  r_wcnt;
   logic [C_SB-1:0]   r_fcnt;
   logic              r_flush_pend;
   logic [31:0]       r_hit_count, r_miss_count;

   // Request address decode
   logic [C_SB-1:0]   w_idx;
   logic [C_TAGW-1:0] w_tag;
   logic [C_WCW-1:0]  w_woff;
   logic [C_SB-1:0]   w_fidx;
   logic [C_TAGW-1:0] w_ftag;

   assign w_idx  = bus.imemaddr[2+C_WB +: C_SB];
   assign w_tag  = bus.imemaddr[31 -: C_TAGW];
   assign w_fidx = r_fill_addr[2+C_WB +: C_SB];
   assign w_ftag = r_fill_addr[31 -: C_TAGW];

   generate
      if (C_WB > 0) begin : g_woff
         assign w_woff = bus.imemaddr[2 +: C_WB];
      end else begin : g_woff_none
         assign w_woff = '0;
      end
   endgenerate

   // Lookup and victim choice. Scanning downward lets the lowest invalid
   // way win.
   logic              w_hit, w_inv_found;
   logic [C_WYW-1:0]  w_hit_way, w_inv_way, w_victim;

   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = C_WYW'(w);
         end
         if (!r_valid[w_idx][w]) begin
            w_inv_found = 1'b1;
            w_inv_way   = C_WYW'(w);
         end
      end
   end

   assign w_victim = w_inv_found ? w_inv_way : r_vptr[w_idx];

   // A flush (registered or arriving now) pre-empts any IDLE lookup.
   logic w_flush_req, w_idle_go, w_do_hit, w_do_miss, w_beat, w_fill_last, w_fl_last;

   assign w_flush_req = r_flush_pend | bus.flush;
   assign w_idle_go   = (r_state == S_IDLE) & ~w_flush_req & bus.imemREN;
   assign w_do_hit    = w_idle_go & w_hit;
   assign w_do_miss   = w_idle_go & ~w_hit;
   assign w_beat      = (r_state == S_FILL) & ~bus.iwait;
   assign w_fill_last = (r_wcnt == C_WCW'(BLOCK_WORDS - 1));
   assign w_fl_last   = (r_fcnt == C_SB'(SETS - 1));

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_flush_req)    w_next = S_FLUSH;
            else if (w_do_miss) w_next = S_FILL;
         end
         S_FILL:  if (w_beat && w_fill_last) w_next = S_IDLE;
         S_FLUSH: if (w_fl_last)             w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.ihit       = w_do_hit;
      bus.imemload   = w_do_hit ? r_data[w_idx][w_hit_way][w_woff] : 32'd0;
      bus.iREN       = (r_state == S_FILL);
      bus.iaddr      = (r_state == S_FILL) ? (r_fill_addr + 32'({r_wcnt, 2'b00})) : 32'd0;
      bus.busy       = (r_state != S_IDLE) | r_flush_pend;
      bus.hit_count  = r_hit_count;
      bus.miss_count = r_miss_count;
   end

   // Control datapath: valid bits, victim pointers, counters, fill/flush state
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_vptr[s]  <= '0;
         end
         r_fill_addr  <= '0;
         r_fill_way   <= '0;
         r_fill_evict <= 1'b0;
         r_wcnt       <= '0;
         r_fcnt       <= '0;
         r_flush_pend <= 1'b0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         // Entry to FLUSH consumes the request; any later flush re-arms it.
         if ((r_state == S_IDLE) && w_flush_req) r_flush_pend <= 1'b0;
         else if (bus.flush)                     r_flush_pend <= 1'b1;

         if (w_do_hit) r_hit_count <= r_hit_count + 32'd1;

         if (w_do_miss) begin
            r_miss_count <= r_miss_count + 32'd1;
            r_fill_addr  <= bus.imemaddr & C_BLK_MASK;
            r_fill_way   <= w_victim;
            r_fill_evict <= ~w_inv_found;
            r_wcnt       <= '0;
         end

         if (w_beat) begin
            if (w_fill_last) begin
               r_wcnt                      <= '0;
               r_valid[w_fidx][r_fill_way] <= 1'b1;
               // Filling an empty way leaves the round-robin order alone.
               if (r_fill_evict && (WAYS > 1))
                  r_vptr[w_fidx] <= r_vptr[w_fidx] + C_WYW'(1);
            end else begin
               r_wcnt <= r_wcnt + C_WCW'(1);
            end
         end

         if (r_state == S_FLUSH) begin
            r_valid[r_fcnt] <= '0;
            r_vptr[r_fcnt]  <= '0;
            r_fcnt          <= w_fl_last ? '0 : (r_fcnt + C_SB'(1));
         end
      end
   end

   // Block data and tags are qualified by valid, so they need no reset.
   always_ff @(posedge CLK) begin
      if (w_beat) r_data[w_fidx][r_fill_way][r_wcnt] <= bus.iload;
      if (w_beat && w_fill_last) r_tag[w_fidx][r_fill_way] <= w_ftag;
   end
endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_assoc
//  Purpose  : Self-checking bench for icache_assoc. Instance 0 uses default
//             parameters (8 sets, 2 ways, 2 words); instance 1 uses 4 sets,
//             1 way, 4 words. A vector table drives single fetches; short
//             hand sequences cover iwait stalls, flush during fill and reset
//             during fill.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icache_assoc;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   // Stimulus, routed to whichever instance sel chooses
   logic        sel      = 1'b0;
   logic        ren      = 1'b0;
   logic [31:0] addr     = 32'd0;
   logic        flush_v  = 1'b0;
   logic        stall_en = 1'b0;
   logic        iwait_v  = 1'b0;
   int          stall_cnt = 0;

   int checks   = 0;
   int failures = 0;

   logic [31:0] beats[$];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[15:0]};
   endfunction

   icache_assoc_if bus0 ();
   icache_assoc_if bus1 ();

   assign bus0.imemREN  = ren & ~sel;
   assign bus0.imemaddr = addr;
   assign bus0.flush    = flush_v & ~sel;
   assign bus0.iwait    = iwait_v & ~sel;
   assign bus0.iload    = memf(bus0.iaddr);

   assign bus1.imemREN  = ren & sel;
   assign bus1.imemaddr = addr;
   assign bus1.flush    = flush_v & sel;
   assign bus1.iwait    = 1'b0;
   assign bus1.iload    = memf(bus1.iaddr);

   icache_assoc dut0 (.CLK(CLK), .RST(RST), .bus(bus0.slave));
   icache_assoc #(.SETS(4), .WAYS(1), .BLOCK_WORDS(4)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1.slave));

   logic        m_ihit, m_busy, m_iREN;
   logic [31:0] m_load, m_iaddr, m_hits, m_misses;
   assign m_ihit   = sel ? bus1.ihit       : bus0.ihit;
   assign m_busy   = sel ? bus1.busy       : bus0.busy;
   assign m_iREN   = sel ? bus1.iREN       : bus0.iREN;
   assign m_load   = sel ? bus1.imemload   : bus0.imemload;
   assign m_iaddr  = sel ? bus1.iaddr      : bus0.iaddr;
   assign m_hits   = sel ? bus1.hit_count  : bus0.hit_count;
   assign m_misses = sel ? bus1.miss_count : bus0.miss_count;

   // Memory stall model: three wait cycles ahead of every accepted beat.
   always @(negedge CLK) begin
      if (stall_en && bus0.iREN) begin
         iwait_v   = (stall_cnt < 3);
         stall_cnt = (stall_cnt == 3) ? 0 : stall_cnt + 1;
      end else begin
         iwait_v   = 1'b0;
         stall_cnt = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Holds the request until ihit; lat counts request cycles including the hit.
   task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] data);
      addr = a;
      ren  = 1'b1;
      lat  = 0;
      data = 32'd0;
      beats.delete();
      for (int c = 0; c < 200; c++) begin
         @(negedge CLK);
         lat++;
         if (m_iREN) beats.push_back(m_iaddr);
         if (m_ihit) begin
            data = m_load;
            break;
         end
      end
      @(posedge CLK);
      #1;
      ren = 1'b0;
   endtask

   typedef struct {
      logic        sel;
      logic [31:0] addr;
      int          lat;
      int          hits;
      int          misses;
   } vec_t;

   vec_t vecs[17];

   initial begin
      int          lat;
      logic [31:0] data;
      int          nb;
      logic [31:0] blk, first, last;
      int          busy_cycles;
      logic        saw_hit;
      logic [31:0] m0;

      // Instance 0: index 0 holds tags 1 (0x40), 2 (0x80), 3 (0xC0)
      vecs[0]  = '{1'b0, 32'h40, 4, 1, 1};   // cold miss
      vecs[1]  = '{1'b0, 32'h44, 1, 2, 1};   // same block, word 1
      vecs[2]  = '{1'b0, 32'h80, 4, 3, 2};   // second way
      vecs[3]  = '{1'b0, 32'h40, 1, 4, 2};
      vecs[4]  = '{1'b0, 32'h84, 1, 5, 2};
      vecs[5]  = '{1'b0, 32'hC0, 4, 6, 3};   // evicts way 0 (0x40)
      vecs[6]  = '{1'b0, 32'h80, 1, 7, 3};
      vecs[7]  = '{1'b0, 32'h40, 4, 8, 4};   // evicts way 1 (0x80)
      vecs[8]  = '{1'b0, 32'hC4, 1, 9, 4};
      vecs[9]  = '{1'b0, 32'h80, 4, 10, 5};  // evicts way 0 (0xC0)
      vecs[10] = '{1'b0, 32'h48, 4, 11, 6};  // index 1
      vecs[11] = '{1'b0, 32'h40, 1, 12, 6};
      // Instance 1: direct-mapped, 0x00 and 0x40 conflict
      vecs[12] = '{1'b1, 32'h00, 6, 1, 1};
      vecs[13] = '{1'b1, 32'h40, 6, 2, 2};
      vecs[14] = '{1'b1, 32'h00, 6, 3, 3};
      vecs[15] = '{1'b1, 32'h40, 6, 4, 4};
      vecs[16] = '{1'b1, 32'h4C, 1, 5, 4};

      // Reset state
      repeat (2) @(negedge CLK);
      check("rst_ihit",   {31'd0, bus0.ihit}, 32'd0);
      check("rst_iREN",   {31'd0, bus0.iREN}, 32'd0);
      check("rst_busy",   {31'd0, bus0.busy}, 32'd0);
      check("rst_iaddr",  bus0.iaddr, 32'd0);
      check("rst_load",   bus0.imemload, 32'd0);
      check("rst_hits",   bus0.hit_count, 32'd0);
      check("rst_misses", bus0.miss_count, 32'd0);
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // Vector table
      for (int i = 0; i < 17; i++) begin
         sel = vecs[i].sel;
         fetch(vecs[i].addr, lat, data);
         check($sformatf("v%0d_lat", i),    lat, vecs[i].lat);
         check($sformatf("v%0d_data", i),   data, memf(vecs[i].addr & ~32'h3));
         check($sformatf("v%0d_hits", i),   m_hits, vecs[i].hits);
         check($sformatf("v%0d_misses", i), m_misses, vecs[i].misses);
         if (vecs[i].lat > 1) begin
            nb    = vecs[i].sel ? 4 : 2;
            blk   = vecs[i].addr & ~((nb * 4) - 1);
            first = (beats.size() > 0) ? beats[0] : 32'hFFFF_FFFF;
            last  = (beats.size() > 0) ? beats[beats.size()-1] : 32'hFFFF_FFFF;
            check($sformatf("v%0d_nbeats", i), beats.size(), nb);
            check($sformatf("v%0d_first", i),  first, blk);
            check($sformatf("v%0d_last", i),   last, blk + (nb - 1) * 4);
         end
      end
      sel = 1'b0;

      // iwait stalls: 3 waits before each of 2 beats -> 8 FILL cycles
      stall_en = 1'b1;
      fetch(32'h1000, lat, data);
      stall_en = 1'b0;
      check("stall_lat",    lat, 10);
      check("stall_nbeats", beats.size(), 8);
      check("stall_b3",     (beats.size() > 3) ? beats[3] : 32'hFFFF_FFFF, 32'h1000);
      check("stall_b4",     (beats.size() > 4) ? beats[4] : 32'hFFFF_FFFF, 32'h1004);
      check("stall_data",   data, memf(32'h1000));

      // Flush pulse during the first fill beat
      m0   = bus0.miss_count;
      addr = 32'h200;
      ren  = 1'b1;
      @(posedge CLK);
      #1;
      flush_v = 1'b1;
      ren     = 1'b0;
      @(posedge CLK);
      #1;
      flush_v     = 1'b0;
      busy_cycles = 0;
      saw_hit     = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (bus0.ihit) saw_hit = 1'b1;
         if (!bus0.busy) break;
         if (!bus0.iREN) busy_cycles++;
      end
      check("flush_busy_cycles", busy_cycles, 9);
      check("flush_no_hit",      {31'd0, saw_hit}, 32'd0);
      check("flush_miss_delta",  bus0.miss_count - m0, 32'd1);
      @(posedge CLK);
      #1;
      fetch(32'h200, lat, data);
      check("flush_refill_200", lat, 4);
      fetch(32'h1000, lat, data);
      check("flush_refill_1000", lat, 4);

      // Reset in the middle of a fill
      addr = 32'h300;
      ren  = 1'b1;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      check("mid_rst_ihit",   {31'd0, bus0.ihit}, 32'd0);
      check("mid_rst_iREN",   {31'd0, bus0.iREN}, 32'd0);
      check("mid_rst_iaddr",  bus0.iaddr, 32'd0);
      check("mid_rst_busy",   {31'd0, bus0.busy}, 32'd0);
      check("mid_rst_load",   bus0.imemload, 32'd0);
      check("mid_rst_hits",   bus0.hit_count, 32'd0);
      check("mid_rst_misses", bus0.miss_count, 32'd0);
      ren = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      fetch(32'h300, lat, data);
      check("post_rst_lat",    lat, 4);
      check("post_rst_first",  (beats.size() > 0) ? beats[0] : 32'hFFFF_FFFF, 32'h300);
      check("post_rst_misses", bus0.miss_count, 32'd1);
      check("post_rst_hits",   bus0.hit_count, 32'd1);
      check("post_rst_data",   data, memf(32'h300));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
